fetch_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end: owns the fetch PC, issues sequential word fetches to instruction memory, and buffers fetched instructions in a DEPTH-entry prefetch FIFO ahead of stage D. It decouples IM latency (im_ready gaps) from D-stage stalls and discards all buffered work in one cycle on a control-flow redirect (branch, jump, exception entry, eret). It sits between the IM port and the D pipeline register, replacing the single-register F stage.

---
 rtl/fetch_prefetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - fetch PC owner with DEPTH-entry prefetch FIFO feeding stage D
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] BOOT_PC  = 32'h0000_3000,
   parameter logic [31:0] IM_START = 32'h0000_3000,
   parameter logic [31:0] IM_END   = 32'h0000_7000,
   parameter logic [4:0]  EXC_ADEL = 5'd4,
   localparam int         PW       = $clog2(DEPTH),
   localparam int         CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   input  logic          stall,
   output logic [31:0]   im_addr,
   output logic          im_req,
   input  logic [31:0]   im_rdata,
   input  logic          im_ready,
   output logic          valid_D,
   output logic [31:0]   code_D,
   output logic [31:0]   PC_D,
   output logic [4:0]    EXC_D,
   output logic [CW-1:0] count
);

   typedef enum logic {S_FETCH, S_HALT} state_t;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   code_mem [DEPTH];
   logic [4:0]    exc_mem  [DEPTH];

   logic          full, bad, push, pop;
   logic [31:0]   push_code;
   logic [4:0]    push_exc;

   assign full = (count_q == FULL_CNT);
   assign bad  = (fetch_pc_q < IM_START) || (fetch_pc_q >= IM_END) || (fetch_pc_q[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = S_FETCH;
      end else if (state_q == S_FETCH && !full && bad) begin
         state_d = S_HALT;
      end
   end

   // A full queue blocks the push even when a pop frees a slot, so im_req never sees stall.
   always_comb begin
      im_req     = 1'b0;
      push       = 1'b0;
      push_code  = im_rdata;
      push_exc   = 5'd0;
      fetch_pc_d = fetch_pc_q;
      if (!redirect && state_q == S_FETCH && !full) begin
         if (bad) begin
            push      = 1'b1;
            push_code = 32'd0;
            push_exc  = EXC_ADEL;
         end else begin
            im_req = 1'b1;
            if (im_ready) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
      end
      if (redirect) begin
         fetch_pc_d = redirect_pc;
      end
   end

   assign valid_D = (count_q != '0);
   assign pop     = valid_D && !stall && !redirect;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= BOOT_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_q <= count_q + CNT_ONE;
            else if (pop && !push) count_q <= count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= fetch_pc_q;
         code_mem[wr_ptr_q] <= push_code;
         exc_mem[wr_ptr_q]  <= push_exc;
      end
   end

   assign im_addr = fetch_pc_q;
   assign count   = count_q;
   assign code_D  = valid_D ? code_mem[rd_ptr_q] : 32'd0;
   assign PC_D    = valid_D ? pc_mem[rd_ptr_q]   : 32'd0;
   assign EXC_D   = valid_D ? exc_mem[rd_ptr_q]  : 5'd0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed vector bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset, redirect, stall, im_ready;
   logic [31:0] redirect_pc, im_addr, im_rdata, code_D, PC_D;
   logic        im_req, valid_D;
   logic [4:0]  EXC_D;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instruction memory model: each word is its own address offset by 0x1000_0000.
   assign im_rdata = im_addr + 32'h1000_0000;

   fetch_prefetch_queue dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .stall(stall), .im_addr(im_addr), .im_req(im_req), .im_rdata(im_rdata),
      .im_ready(im_ready), .valid_D(valid_D), .code_D(code_D), .PC_D(PC_D),
      .EXC_D(EXC_D), .count(count)
   );

   typedef struct {
      logic        rst, redir;
      logic [31:0] rpc;
      logic        stl, rdy;
      logic        vld;
      logic [31:0] pc, code;
      logic [4:0]  exc;
      logic [2:0]  cnt;
      logic        req;
      logic [31:0] addr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic stl, input logic rdy, input logic vld,
                      input logic [31:0] pc, input logic [4:0] exc,
                      input logic [2:0] cnt, input logic req, input logic [31:0] addr);
      vec_t v;
      v.rst = rst; v.redir = redir; v.rpc = rpc; v.stl = stl; v.rdy = rdy;
      v.vld = vld; v.pc = pc; v.exc = exc; v.cnt = cnt; v.req = req; v.addr = addr;
      v.code = (vld && exc == 5'd0) ? pc + 32'h1000_0000 : 32'd0;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      //   rst rd rpc           st rdy  v  pc            exc  cnt req addr
      add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   0,  1,  32'h3000); // reset state
      add(0, 0, 32'h0,        0, 1,   1, 32'h3000,     0,   1,  1,  32'h3004);
      add(0, 0, 32'h0,        0, 1,   1, 32'h3004,     0,   1,  1,  32'h3008);
      add(0, 0, 32'h0,        1, 1,   1, 32'h3008,     0,   1,  1,  32'h300C);
      add(0, 0, 32'h0,        1, 1,   1, 32'h3008,     0,   2,  1,  32'h3010);
      add(0, 0, 32'h0,        1, 1,   1, 32'h3008,     0,   3,  1,  32'h3014);
      add(0, 0, 32'h0,        1, 1,   1, 32'h3008,     0,   4,  0,  32'h3018); // full
      add(0, 0, 32'h0,        0, 1,   1, 32'h3008,     0,   4,  0,  32'h3018); // pop, no push
      add(0, 0, 32'h0,        0, 1,   1, 32'h300C,     0,   3,  1,  32'h3018);
      add(0, 0, 32'h0,        0, 0,   1, 32'h3010,     0,   3,  1,  32'h301C); // im_ready gap
      add(0, 0, 32'h0,        0, 0,   1, 32'h3014,     0,   2,  1,  32'h301C);
      add(0, 0, 32'h0,        0, 1,   1, 32'h3018,     0,   1,  1,  32'h301C);
      add(0, 0, 32'h0,        1, 1,   1, 32'h301C,     0,   1,  1,  32'h3020);
      add(0, 0, 32'h0,        1, 1,   1, 32'h301C,     0,   2,  1,  32'h3024);
      add(0, 1, 32'h3400,     0, 1,   1, 32'h301C,     0,   3,  0,  32'h3028); // redirect, 3 queued
      add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   0,  1,  32'h3400);
      add(0, 0, 32'h0,        0, 1,   1, 32'h3400,     0,   1,  1,  32'h3404);
      add(0, 1, 32'h3402,     0, 1,   1, 32'h3404,     0,   1,  0,  32'h3408); // misaligned target
      add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   0,  0,  32'h3402);
      add(0, 0, 32'h0,        1, 1,   1, 32'h3402,     4,   1,  0,  32'h3402);
      add(0, 0, 32'h0,        0, 1,   1, 32'h3402,     4,   1,  0,  32'h3402);
      add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   0,  0,  32'h3402); // halted
      add(0, 1, 32'h6FFC,     0, 1,   0, 32'h0,        0,   0,  0,  32'h3402);
      add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   0,  1,  32'h6FFC);
      add(0, 0, 32'h0,        0, 1,   1, 32'h6FFC,     0,   1,  0,  32'h7000); // past IM_END
      add(0, 0, 32'h0,        0, 1,   1, 32'h7000,     4,   1,  0,  32'h7000);
      add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   0,  0,  32'h7000);
      add(0, 1, 32'h3000,     0, 1,   0, 32'h0,        0,   0,  0,  32'h7000);
      add(0, 0, 32'h0,        1, 1,   0, 32'h0,        0,   0,  1,  32'h3000);
      add(0, 0, 32'h0,        1, 1,   1, 32'h3000,     0,   1,  1,  32'h3004);
      add(0, 0, 32'h0,        1, 1,   1, 32'h3000,     0,   2,  1,  32'h3008);
      add(0, 0, 32'h0,        0, 1,   1, 32'h3000,     0,   3,  1,  32'h300C); // push+pop at DEPTH-1
      add(0, 0, 32'h0,        0, 1,   1, 32'h3004,     0,   3,  1,  32'h3010);
      add(0, 0, 32'h0,        0, 1,   1, 32'h3008,     0,   3,  1,  32'h3014);
      add(0, 0, 32'h0,        0, 1,   1, 32'h300C,     0,   3,  1,  32'h3018);
      add(1, 1, 32'h3400,     0, 1,   1, 32'h3010,     0,   3,  0,  32'h301C); // reset beats redirect
      add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   0,  1,  32'h3000);
      add(0, 0, 32'h0,        0, 0,   1, 32'h3000,     0,   1,  1,  32'h3004);
      add(0, 0, 32'h0,        0, 0,   0, 32'h0,        0,   0,  1,  32'h3004);

      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0; im_ready = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         reset       = tbl[i].rst;
         redirect    = tbl[i].redir;
         redirect_pc = tbl[i].rpc;
         stall       = tbl[i].stl;
         im_ready    = tbl[i].rdy;
         #1;
         chk("valid_D", i, {31'd0, valid_D}, {31'd0, tbl[i].vld});
         chk("PC_D",    i, PC_D,              tbl[i].pc);
         chk("code_D",  i, code_D,            tbl[i].code);
         chk("EXC_D",   i, {27'd0, EXC_D},    {27'd0, tbl[i].exc});
         chk("count",   i, {29'd0, count},    {29'd0, tbl[i].cnt});
         chk("im_req",  i, {31'd0, im_req},   {31'd0, tbl[i].req});
         chk("im_addr", i, im_addr,           tbl[i].addr);
      end

      // Redirect while full: fill under stall within a bounded number of cycles.
      begin
         int n = 0;
         @(negedge clk);
         reset = 1'b0; redirect = 1'b0; stall = 1'b1; im_ready = 1'b1;
         #1;
         while (count != 3'd4 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk("fill_to_full", 100, {29'd0, count}, 32'd4);
         chk("full_im_req",  100, {31'd0, im_req}, 32'd0);
         chk("full_head_pc", 100, PC_D, 32'h3004);
         @(negedge clk);
         redirect = 1'b1; redirect_pc = 32'h3100;
         #1;
         chk("redir_full_req", 101, {31'd0, im_req}, 32'd0);
         @(negedge clk);
         redirect = 1'b0; stall = 1'b0;
         #1;
         chk("redir_full_cnt",   102, {29'd0, count}, 32'd0);
         chk("redir_full_valid", 102, {31'd0, valid_D}, 32'd0);
         chk("redir_full_addr",  102, im_addr, 32'h3100);
         chk("redir_full_req2",  102, {31'd0, im_req}, 32'd1);
         @(negedge clk);
         #1;
         chk("redir_full_pc",   103, PC_D, 32'h3100);
         chk("redir_full_code", 103, code_D, 32'h1000_3100);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
